hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum memory-wait cycles before abort (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports Rs1_D and Rs2_D, input, 5 bits each: source register numbers of the instruction in Decode.
REQ-006 SHALL have ports Rs1_E and Rs2_E, input, 5 bits each: source register numbers of the instruction in Execute.
REQ-007 SHALL have ports RD_E, RD_M, RD_W and RD_F, input, 5 bits each: destination registers in Execute, Memory, Writeback and Final stages.
REQ-008 SHALL have ports RegWriteM, RegWriteW and RegWriteF, input, 1 bit each: the destination in that stage will be written.
REQ-009 SHALL have port LoadE, input, 1 bit: the Execute instruction is a load.
REQ-010 SHALL have ports LoadM and StoreM, input, 1 bit each: the Memory instruction is a load or a store.
REQ-011 SHALL have port MemReadyM, input, 1 bit: data memory has completed the current access.
REQ-012 SHALL have port PCSrcE, input, 1 bit: a branch or jump in Execute is taken.
REQ-013 SHALL have port CntClr, input, 1 bit: synchronous clear of the counters.
REQ-014 SHALL have ports ForwardA_E and ForwardB_E, output, 2 bits each: operand select; 00 register file, 01 ResultW, 10 ALU_ResultM, 11 ResultF.
REQ-015 SHALL have ports StallF, StallD, StallE and StallM, output, 1 bit each: hold the pipeline register of that stage.
REQ-016 SHALL have ports FlushD, FlushE and FlushW, output, 1 bit each: insert a bubble into that stage register.
REQ-017 SHALL have port MemErr, output, 1 bit: one-cycle pulse indicating a memory timeout.
REQ-018 SHALL have ports StallCnt and FlushCnt, output, CNT_W bits each: cycles with any stall asserted; cycles with any flush asserted.

Function
REQ-019 SHALL compute the ForwardA_E select combinationally with priority: M (RegWriteM, RD_M!=0, RD_M==Rs1_E) gives 10; else the equivalent W condition gives 01; else the equivalent F condition gives 11; else 00.
REQ-020 SHALL compute ForwardB_E identically to ForwardA_E, using Rs2_E.
REQ-021 SHALL have a registered FSM with states RUN and MEM_WAIT, plus an 8-bit wait counter WCnt.
REQ-022 SHALL detect memory wait as MW = (LoadM|StoreM) & !MemReadyM.
REQ-023 SHALL, in RUN with MW=1, assert StallF/D/E/M and FlushW, drive all other flushes 0, go to MEM_WAIT, and set WCnt=1.
REQ-024 SHALL, in MEM_WAIT with MW=1 and WCnt<TIMEOUT, keep the REQ-023 outputs asserted and increment WCnt.
REQ-025 SHALL, in MEM_WAIT with MW=0, drop all stalls in that same cycle and return to RUN with WCnt=0.
REQ-026 SHALL, in MEM_WAIT with WCnt==TIMEOUT and MW=1, pulse MemErr for exactly that cycle, deassert stalls, and return to RUN with WCnt=0.
REQ-027 SHALL, in RUN with MW=0 and PCSrcE=1, assert FlushD and FlushE with no stalls.
REQ-028 SHALL, in RUN with MW=0, PCSrcE=0, LoadE=1, RD_E!=0 and RD_E equal to Rs1_D or Rs2_D, assert StallF, StallD and FlushE.
REQ-029 SHALL resolve simultaneous events with priority memory wait > branch flush > load-use; a load-use hazard coinciding with PCSrcE=1 produces no stall.
REQ-030 SHALL keep ForwardA_E and ForwardB_E valid in every state, including MEM_WAIT.
REQ-031 SHALL increment StallCnt each cycle any Stall output is 1, and FlushCnt each cycle any Flush output is 1.
REQ-032 SHALL make both counters saturate at all-ones (no wrap).
REQ-033 SHALL give CntClr priority over increment, so the counter reads 0 on the next cycle.

Reset
REQ-034 SHALL, while rst=0, force state RUN, WCnt=0, StallCnt=0, FlushCnt=0 and MemErr=0, and hold every Stall and Flush output at 0, independent of clk.
REQ-035 SHALL, when reset is asserted mid-MEM_WAIT, abort the wait immediately, emit no MemErr pulse, and resume in RUN at the first clock edge after release.

Verification
REQ-036 SHALL verify: RegWriteM=1, RD_M=5, Rs1_E=5, RegWriteW=1, RD_W=5 -> ForwardA_E=10; then RD_M=0 -> ForwardA_E=01.
REQ-037 SHALL verify: LoadE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCnt 0->1; then LoadE=0 -> all outputs 0.
REQ-038 SHALL verify: LoadE=1, RD_E=7, Rs1_D=7 together with PCSrcE=1 -> FlushD=FlushE=1, StallF=0, StallCnt unchanged.
REQ-039 SHALL verify: LoadM=1 with MemReadyM low for 3 cycles -> StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles, then RUN, StallCnt=3, MemErr never 1.
REQ-040 SHALL verify: StoreM=1 with MemReadyM held low, TIMEOUT=16 -> MemErr=1 only in the 16th wait cycle, then stalls drop.
REQ-041 SHALL verify: rst driven low in wait cycle 2 -> all outputs 0 asynchronously, counters 0; and with StallCnt preset to all-ones plus a stall -> it stays all-ones, and CntClr -> 0.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: operand forwarding, load-use/branch hazard resolution and memory-wait
// handling with timeout abort, plus saturating stall/flush cycle counters.
module hazard_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic [4:0]       RD_F,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             RegWriteF,
    input  logic             LoadE,
    input  logic             LoadM,
    input  logic             StoreM,
    input  logic             MemReadyM,
    input  logic             PCSrcE,
    input  logic             CntClr,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t             state_q, state_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_d, flush_cnt_d;
    logic               mw, timeout, mem_stall, free, branch, load_use, any_stall, any_flush;

    function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rdm, input logic wm,
                                       input logic [4:0] rdw, input logic ww,
                                       input logic [4:0] rdf, input logic wf);
        fwd = (wm && rdm != 5'd0 && rdm == rs) ? 2'b10 :
              (ww && rdw != 5'd0 && rdw == rs) ? 2'b01 :
              (wf && rdf != 5'd0 && rdf == rs) ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        ForwardA_E = fwd(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW, RD_F, RegWriteF);
        ForwardB_E = fwd(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW, RD_F, RegWriteF);
    end

    // Control outputs are gated by rst so they fall to 0 the moment reset asserts.
    always_comb begin
        mw        = (LoadM | StoreM) & ~MemReadyM;
        timeout   = (state_q == MEM_WAIT) && (wcnt_q == TMO);
        mem_stall = rst & mw & ~timeout;
        MemErr    = rst & mw & timeout;
        free      = rst & ~mw;
        branch    = free & PCSrcE;
        load_use  = free & ~PCSrcE & LoadE & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
        StallF    = mem_stall | load_use;
        StallD    = mem_stall | load_use;
        StallE    = mem_stall;
        StallM    = mem_stall;
        FlushD    = branch;
        FlushE    = branch | load_use;
        FlushW    = mem_stall;
        any_stall = StallF | StallD | StallE | StallM;
        any_flush = FlushD | FlushE | FlushW;
        state_d   = mem_stall ? MEM_WAIT : RUN;
        wcnt_d    = mem_stall ? wcnt_q + 8'd1 : 8'd0;
        stall_cnt_d = CntClr ? '0 : (any_stall && !(&StallCnt)) ? StallCnt + 1'b1 : StallCnt;
        flush_cnt_d = CntClr ? '0 : (any_flush && !(&FlushCnt)) ? FlushCnt + 1'b1 : FlushCnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            wcnt_q   <= 8'd0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            StallCnt <= stall_cnt_d;
            FlushCnt <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven forwarding/hazard vectors plus directed multi-cycle
// sequences for memory wait, timeout, async reset and counter saturation.
module tb_hazard_controller;
    logic        clk, rst;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W, RD_F;
    logic        RegWriteM, RegWriteW, RegWriteF, LoadE, LoadM, StoreM, MemReadyM, PCSrcE, CntClr;
    logic [1:0]  ForwardA_E, ForwardB_E, s_fa, s_fb;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_me;
    logic [31:0] StallCnt, FlushCnt;
    logic [3:0]  s_scnt, s_fcnt;
    int          checks = 0, errors = 0;

    hazard_controller u_dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RD_F(RD_F),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RegWriteF(RegWriteF),
        .LoadE(LoadE), .LoadM(LoadM), .StoreM(StoreM), .MemReadyM(MemReadyM),
        .PCSrcE(PCSrcE), .CntClr(CntClr),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    hazard_controller #(.TIMEOUT(16), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .RD_F(RD_F),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .RegWriteF(RegWriteF),
        .LoadE(LoadE), .LoadM(LoadM), .StoreM(StoreM), .MemReadyM(MemReadyM),
        .PCSrcE(PCSrcE), .CntClr(CntClr),
        .ForwardA_E(s_fa), .ForwardB_E(s_fb),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
        .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw), .MemErr(s_me),
        .StallCnt(s_scnt), .FlushCnt(s_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, rdf;
        logic [2:0] rw;
        logic       loade, pcsrc;
        logic [1:0] fa, fb;
        logic [3:0] stl;
        logic [2:0] fls;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W, RD_F} = '0;
        {RegWriteM, RegWriteW, RegWriteF, LoadE, LoadM, StoreM, PCSrcE, CntClr} = '0;
        MemReadyM = 1'b1;
    endtask

    function automatic logic [8:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, 1'b0};
    endfunction

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 3'b110, 1'b0, 1'b0, 2'b10, 2'b00, 4'b0000, 3'b000};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 3'b110, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0000, 3'b000};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 3'b001, 1'b0, 1'b0, 2'b00, 2'b11, 4'b0000, 3'b000};
        vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 5'd3, 3'b111, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0000, 3'b000};
        vecs[5]  = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd3, 5'd3, 5'd4, 3'b011, 1'b0, 1'b0, 2'b01, 2'b11, 4'b0000, 3'b000};
        vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b111, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000};
        vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1100, 3'b010};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b1, 2'b00, 2'b00, 4'b0000, 3'b110};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000};
        vecs[10] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 3'b110};
        vecs[12] = '{5'd8, 5'd6, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000};

        // Reset held with a live load-use hazard on the inputs: outputs must stay 0.
        clr_in();
        rst = 1'b0;
        LoadE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
        tick();
        chk("reset_ctl", ctl(), 9'h0);
        chk("reset_stallcnt", StallCnt, 0);
        chk("reset_flushcnt", FlushCnt, 0);
        clr_in();
        #2 rst = 1'b1;
        tick();

        // Load-use on Rs2_D for one cycle.
        LoadE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
        #1 chk("lu_ctl", ctl(), {4'b1100, 3'b010, 1'b0, 1'b0});
        tick();
        chk("lu_stallcnt", StallCnt, 1);
        LoadE = 1'b0;
        #1 chk("lu_release_ctl", ctl(), 9'h0);
        tick();
        chk("lu_release_stallcnt", StallCnt, 1);

        // Load-use coinciding with a taken branch: flush wins, no stall.
        LoadE = 1'b1; RD_E = 5'd7; Rs1_D = 5'd7; Rs2_D = 5'd0; PCSrcE = 1'b1;
        #1 chk("lu_branch_ctl", ctl(), {4'b0000, 3'b110, 1'b0, 1'b0});
        tick();
        chk("lu_branch_stallcnt", StallCnt, 1);
        chk("lu_branch_flushcnt", FlushCnt, 2);
        clr_in();

        for (int i = 0; i < 13; i++) begin
            {Rs1_D, Rs2_D, Rs1_E, Rs2_E} = {vecs[i].rs1d, vecs[i].rs2d, vecs[i].rs1e, vecs[i].rs2e};
            {RD_E, RD_M, RD_W, RD_F} = {vecs[i].rde, vecs[i].rdm, vecs[i].rdw, vecs[i].rdf};
            {RegWriteM, RegWriteW, RegWriteF} = vecs[i].rw;
            LoadE = vecs[i].loade; PCSrcE = vecs[i].pcsrc;
            #1;
            chk($sformatf("vec%0d_fwd", i), {ForwardA_E, ForwardB_E}, {vecs[i].fa, vecs[i].fb});
            chk($sformatf("vec%0d_ctl", i), ctl(), {vecs[i].stl, vecs[i].fls, 1'b0, 1'b0});
            tick();
        end
        clr_in();

        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        chk("cntclr_stall", StallCnt, 0);
        chk("cntclr_flush", FlushCnt, 0);

        // Load waits three cycles, with forwarding kept live through the wait.
        LoadM = 1'b1; MemReadyM = 1'b0;
        RegWriteW = 1'b1; RD_W = 5'd12; Rs2_E = 5'd12;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("memwait%0d_ctl", i), ctl(), {4'b1111, 3'b001, 1'b0, 1'b0});
            chk($sformatf("memwait%0d_fwdb", i), ForwardB_E, 2'b01);
            tick();
        end
        MemReadyM = 1'b1;
        #1 chk("memwait_done_ctl", ctl(), 9'h0);
        tick();
        chk("memwait_stallcnt", StallCnt, 3);
        clr_in();
        tick();

        // Store never completes: 16 stall cycles, then MemErr alone on the 16th MEM_WAIT cycle.
        StoreM = 1'b1; MemReadyM = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            #1 chk($sformatf("timeout_c%0d", n), ctl(),
                   (n <= 16) ? {4'b1111, 3'b001, 1'b0, 1'b0} : {4'b0000, 3'b000, 1'b1, 1'b0});
            tick();
        end
        StoreM = 1'b0; MemReadyM = 1'b1;
        #1 chk("timeout_after_ctl", ctl(), 9'h0);
        tick();

        // Async reset in wait cycle 2.
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        LoadM = 1'b1; MemReadyM = 1'b0;
        tick();
        #1 rst = 1'b0;
        #1 chk("rst_midwait_ctl", ctl(), 9'h0);
        chk("rst_midwait_stallcnt", StallCnt, 0);
        tick();
        chk("rst_held_ctl", ctl(), 9'h0);
        #2 rst = 1'b1;
        #1 chk("rst_release_ctl", ctl(), {4'b1111, 3'b001, 1'b0, 1'b0});
        tick();
        MemReadyM = 1'b1;
        #1 chk("rst_resume_done_ctl", ctl(), 9'h0);
        clr_in();
        tick();

        // Saturation on the 4-bit instance: 20 load-use cycles.
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        LoadE = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3;
        repeat (20) tick();
        chk("sat_stallcnt", s_scnt, 4'hF);
        chk("sat_flushcnt", s_fcnt, 4'hF);
        chk("wide_stallcnt", StallCnt, 20);
        tick();
        chk("sat_hold_stallcnt", s_scnt, 4'hF);
        CntClr = 1'b1;
        tick();
        chk("sat_clr_stallcnt", s_scnt, 4'h0);
        chk("sat_clr_flushcnt", s_fcnt, 4'h0);
        clr_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
